pc_redirect_unit: RTL and testbench
===================================

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter: CNT_W, 16, width of the redirect performance counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: stall  input  1  hazard hold; the PC does not advance.
REQ-006 SHALL have port: branch_taken  input  1  conditional branch resolved taken in the MEM stage (from the branch decision unit).
REQ-007 SHALL have port: jump  input  1  unconditional JAL/JALR in the MEM stage.
REQ-008 SHALL have port: target  input  32  redirect address for a taken branch or jump.
REQ-009 SHALL have port: halt  input  1  ECALL/EBREAK reached MEM; freezes fetch.
REQ-010 SHALL have port: pc  output  32  current fetch address (registered).
REQ-011 SHALL have port: pc_plus4  output  32  pc+4, combinational, modulo 2^32.
REQ-012 SHALL have port: flush_ifid, flush_idex, flush_exmem  output  1 each  squash the three younger pipeline registers.
REQ-013 SHALL have port: fetch_en  output  1  instruction memory read enable.
REQ-014 SHALL have port: misalign_err  output  1  sticky flag: an accepted target was not word-aligned.
REQ-015 SHALL have port: redirect_cnt  output  CNT_W  saturating count of accepted redirects.

Function
REQ-016 SHALL implement FSM states RUN, SHADOW and HALTED.
REQ-017 SHALL define req = branch_taken | jump.
REQ-018 SHALL define accept = (state==RUN) & req & ~halt.
REQ-019 On accept, SHALL load pc <= {target[31:2],2'b00} at the next edge, regardless of stall (redirect has priority over stall).
REQ-020 On accept, SHALL assert flush_ifid, flush_idex and flush_exmem combinationally in the same cycle, and otherwise hold them 0.
REQ-021 On accept, SHALL transition RUN->SHADOW.
REQ-022 In SHADOW (exactly one cycle), SHALL ignore req and produce no flush; pc <= pc+4 unless stall; then SHADOW->RUN.
REQ-023 In RUN with no accept and no halt: stall=1 SHALL hold pc; stall=0 SHALL set pc <= pc+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-024 halt=1 in RUN or SHADOW SHALL move to HALTED at the next edge with pc unchanged; halt SHALL win over a simultaneous req (no pc load, no flush, no count).
REQ-025 HALTED SHALL be terminal until rst: pc frozen, flushes 0, req and stall ignored.
REQ-026 fetch_en SHALL be 1 in RUN and SHADOW, and 0 in HALTED and while rst=1.
REQ-027 On accept with target[1:0]!=0, SHALL set misalign_err to 1; it SHALL stay set until rst.
REQ-028 On accept, SHALL increment redirect_cnt by 1, saturating at all-ones with no wrap.

Reset
REQ-029 While rst=1, SHALL immediately force pc=RESET_PC, state=RUN, redirect_cnt=0, misalign_err=0.
REQ-030 While rst=1, SHALL gate all flushes and fetch_en to 0 combinationally.
REQ-031 Reset asserted mid-SHADOW or in HALTED SHALL abandon that state with no residual flush.
REQ-032 On the first edge after rst deasserts, SHALL fetch from RESET_PC.

Structure
REQ-033 SHALL take the state enum (RUN/SHADOW/HALTED), XLEN=32 and the default RESET_PC from shared package cpu_pkg.
REQ-034 SHALL instantiate sub-module sat_counter (parameter W, inputs clk/rst/inc, output count) for redirect_cnt; all other logic SHALL be inline.

Verification
REQ-035 Bench SHALL cover: reset release, stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; fetch_en=1.
REQ-036 Bench SHALL cover: branch_taken=1, target=0x100 at pc=0x20 with stall=1 -> three flushes high that cycle; next pc=0x100; redirect_cnt=1; one SHADOW cycle.
REQ-037 Bench SHALL cover: jump=1 in SHADOW cycle after a redirect -> no flush, pc=0x104, redirect_cnt unchanged.
REQ-038 Bench SHALL cover: halt=1 with branch_taken=1, target=0x200 at pc=0x40 -> no flush, HALTED, pc stays 0x40, fetch_en=0 through 10 further cycles.
REQ-039 Bench SHALL cover: jump=1, target=0x302 -> pc=0x300, misalign_err=1, persisting until rst.
REQ-040 Bench SHALL cover: CNT_W=2 with 5 accepted redirects -> redirect_cnt saturates at 3; pc=0xFFFF_FFFC with stall=0 -> next pc 0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default reset vector and the
// fetch-control state encoding used by the PC redirect logic.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHADOW = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Force an address onto a 4-byte instruction boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increments, holding once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, one-cycle post-redirect
// shadow, terminal halt, pipeline flush generation and redirect statistics.
module pc_redirect_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [XLEN-1:0]  target,
  input  logic             halt,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             fetch_en,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc_next;
  logic            req;
  logic            accept;
  logic            flush;

  assign req      = branch_taken | jump;
  assign pc_plus4 = pc + XLEN'(4);

  // State and PC register; reset pins fetch to the reset vector in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next state / next PC: halt beats redirect, redirect beats stall.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    accept     = 1'b0;
    unique case (state)
      RUN: begin
        if (halt) begin
          state_next = HALTED;
        end else if (req) begin
          accept     = 1'b1;
          pc_next    = align_word(target);
          state_next = SHADOW;
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      SHADOW: begin
        if (halt) begin
          state_next = HALTED;
        end else begin
          state_next = RUN;
          if (!stall) begin
            pc_next = pc_plus4;
          end
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Flushes and fetch enable are masked by reset so nothing leaks out of
  // an abandoned SHADOW or HALTED state.
  always_comb begin
    flush    = accept & ~rst;
    fetch_en = ~rst & (state != HALTED);
  end

  assign flush_ifid  = flush;
  assign flush_idex  = flush;
  assign flush_exmem = flush;

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (accept && (target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .count(redirect_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: two instances (16-bit and 2-bit
// redirect counters) share stimulus and are checked every cycle against a
// rule-level model, plus hand-computed expectations at key points.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] target = '0;

  logic [31:0] pc_a, pc4_a, pc_b, pc4_b;
  logic        fi_a, fd_a, fe_a, fi_b, fd_b, fe_b;
  logic        fen_a, fen_b, mis_a, mis_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          started  = 1'b0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .target(target), .halt(halt),
    .pc(pc_a), .pc_plus4(pc4_a), .flush_ifid(fi_a), .flush_idex(fd_a),
    .flush_exmem(fe_a), .fetch_en(fen_a), .misalign_err(mis_a),
    .redirect_cnt(cnt_a)
  );

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .target(target), .halt(halt),
    .pc(pc_b), .pc_plus4(pc4_b), .flush_ifid(fi_b), .flush_idex(fd_b),
    .flush_exmem(fe_b), .fetch_en(fen_b), .misalign_err(mis_b),
    .redirect_cnt(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Rule-level model: fetch address, whether the last cycle redirected,
  // whether fetch is frozen, number of accepted redirects, misalign seen.
  logic [31:0] m_pc     = 32'h0;
  bit          m_shadow = 1'b0;
  bit          m_halted = 1'b0;
  int unsigned m_nacc   = 0;
  bit          m_mis    = 1'b0;

  function automatic bit m_accept();
    return !rst && !m_halted && !m_shadow && (branch_taken || jump) && !halt;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_shadow = 0; m_halted = 0; m_nacc = 0; m_mis = 0;
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1;
      end else if (m_shadow) begin
        m_shadow = 0;
        if (!stall) m_pc = m_pc + 32'd4;
      end else if (branch_taken || jump) begin
        m_pc     = target & 32'hFFFF_FFFC;
        m_shadow = 1;
        m_nacc   = m_nacc + 1;
        if (target % 4 != 0) m_mis = 1;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      logic [31:0] exp_fl;
      exp_fl = m_accept() ? 32'h7 : 32'h0;
      chk("pc_a", pc_a, m_pc);
      chk("pc_b", pc_b, m_pc);
      chk("pc4_a", pc4_a, m_pc + 32'd4);
      chk("pc4_b", pc4_b, m_pc + 32'd4);
      chk("flush_a", {29'b0, fi_a, fd_a, fe_a}, exp_fl);
      chk("flush_b", {29'b0, fi_b, fd_b, fe_b}, exp_fl);
      chk("fetch_en_a", {31'b0, fen_a}, {31'b0, (!rst && !m_halted)});
      chk("fetch_en_b", {31'b0, fen_b}, {31'b0, (!rst && !m_halted)});
      chk("mis_a", {31'b0, mis_a}, {31'b0, m_mis});
      chk("mis_b", {31'b0, mis_b}, {31'b0, m_mis});
      chk("cnt16", {16'b0, cnt_a}, (m_nacc > 65535) ? 32'd65535 : m_nacc);
      chk("cnt2", {30'b0, cnt_b}, (m_nacc > 3) ? 32'd3 : m_nacc);
    end
  end

  // Drive one cycle of inputs just after the edge, then wait to sample.
  task automatic drive(input logic s, input logic b, input logic j,
                       input logic h, input logic [31:0] t);
    @(posedge clk); #1;
    stall = s; branch_taken = b; jump = j; halt = h; target = t;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [31:0] exp_pc,
                     input logic exp_fl, input logic exp_fen);
    chk({nm, "_pc"}, pc_a, exp_pc);
    chk({nm, "_flush"}, {31'b0, fi_a & fd_a & fe_a}, {31'b0, exp_fl});
    chk({nm, "_fen"}, {31'b0, fen_a}, {31'b0, exp_fen});
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    lit("rst", 32'h0, 1'b0, 1'b0);
    chk("rst_cnt", {16'b0, cnt_a}, 32'h0);

    // Reset release and sequential fetch, with one stalled cycle.
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    lit("rel", 32'h0, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 0); lit("seq4", 32'h4, 0, 1);
    drive(0, 0, 0, 0, 0); lit("seq8", 32'h8, 0, 1);
    drive(0, 0, 0, 0, 0); lit("seqC", 32'hC, 0, 1);
    drive(1, 0, 0, 0, 0); lit("seq10", 32'h10, 0, 1);
    drive(0, 0, 0, 0, 0); lit("stall10", 32'h10, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Taken branch while stalled: flush now, redirect next.
    drive(1, 1, 0, 0, 32'h100); lit("br", 32'h20, 1, 1);
    // Shadow cycle ignores the jump.
    drive(0, 0, 1, 0, 32'h500); lit("shadow", 32'h100, 0, 1);
    chk("shadow_cnt", {16'b0, cnt_a}, 32'd1);
    drive(1, 0, 1, 0, 32'h40); lit("after_sh", 32'h104, 1, 1);
    chk("after_sh_cnt", {16'b0, cnt_a}, 32'd1);
    drive(1, 0, 0, 0, 0); lit("sh2", 32'h40, 0, 1);

    // Halt beats a simultaneous branch; fetch stays frozen.
    drive(0, 1, 0, 1, 32'h200); lit("halt", 32'h40, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), $urandom);
      lit("halted", 32'h40, 0, 0);
    end

    // Reset out of HALTED.
    @(posedge clk); #1; rst = 1'b1; stall = 0; branch_taken = 0; jump = 0; halt = 0;
    @(negedge clk); lit("rst2", 32'h0, 0, 0);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    lit("rel2", 32'h0, 0, 1);

    // Misaligned jump and saturation of the 2-bit counter.
    drive(0, 0, 1, 0, 32'h302); lit("mj", 32'h4, 1, 1);
    drive(1, 0, 0, 0, 0); lit("mj_pc", 32'h300, 0, 1);
    chk("mis_set", {31'b0, mis_a}, 32'd1);
    drive(0, 1, 0, 0, 32'h1000);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 32'h2000);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 32'h3000);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 32'hFFFF_FFFC); lit("j5", 32'h3004, 1, 1);
    drive(1, 0, 0, 0, 0); lit("top", 32'hFFFF_FFFC, 0, 1);
    chk("sat2", {30'b0, cnt_b}, 32'd3);
    chk("cnt5", {16'b0, cnt_a}, 32'd5);
    chk("pc4_wrap", pc4_a, 32'h0);
    drive(0, 0, 0, 0, 0); lit("top2", 32'hFFFF_FFFC, 0, 1);
    drive(0, 0, 0, 0, 0); lit("wrap", 32'h0, 0, 1);
    chk("mis_hold", {31'b0, mis_a}, 32'd1);

    // Reset asserted mid-SHADOW clears everything with no flush.
    drive(0, 0, 1, 0, 32'h80); lit("j80", 32'h4, 1, 1);
    @(posedge clk); #1; rst = 1'b1; jump = 0;
    @(negedge clk); lit("rst_sh", 32'h0, 0, 0);
    chk("mis_clr", {31'b0, mis_a}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    lit("rel3", 32'h0, 0, 1);

    // Halt during SHADOW.
    drive(0, 0, 1, 0, 32'h80);
    drive(0, 0, 0, 1, 0); lit("sh_halt", 32'h80, 0, 1);
    drive(0, 1, 0, 0, 32'h400); lit("sh_halted", 32'h80, 0, 0);
    drive(0, 0, 0, 0, 0);

    @(posedge clk); #1;
    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
